// File: rtl/sid_mix_seq.sv
// Time-multiplexed SID voice mixer: one voice per clock into filter/bypass sums, then clip and
// master volume. Optional DC offset term enabled by defining SID_MIX_DC_EN.
module sid_mix_seq #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned HEADROOM   = 3
) (
  input  logic                           clk,
  input  logic                           iRstN,
  input  logic                           clkEn,
  input  logic [NUM_VOICES*WIDTH-1:0]    iVoices,
  input  logic [NUM_VOICES-1:0]          iFilt,
  input  logic [NUM_VOICES-1:0]          iOff,
  input  logic [2:0]                     iMode,
  input  logic [3:0]                     iVol,
  input  logic signed [WIDTH-1:0]        iLP,
  input  logic signed [WIDTH-1:0]        iBP,
  input  logic signed [WIDTH-1:0]        iHP,
  input  logic                           iClr,
  output logic signed [WIDTH-1:0]        oPreFilter,
  output logic signed [WIDTH-1:0]        oOut,
  output logic                           oValid,
  output logic                           oOverrun,
  output logic [7:0]                     oClipCnt
);

  localparam int unsigned AccW = WIDTH + $clog2(NUM_VOICES + 4) + 1;
  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_VOICES - 1);
  localparam logic signed [AccW-1:0] MaxAcc = AccW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [AccW-1:0] MinAcc = ~MaxAcc;
  localparam logic signed [WIDTH-1:0] MaxOut = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MinOut = ~MaxOut;

  typedef enum logic [1:0] {StIdle, StAcc, StMix, StVol} state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic signed [AccW-1:0]   facc_q, facc_d, bacc_q, bacc_d;
  logic signed [WIDTH-1:0]  clip_q, clip_d, pf_q, pf_d;
  logic signed [WIDTH-1:0]  out_q, out_d, pre_q, pre_d;
  logic                     valid_q, valid_d, ovr_q, ovr_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     latch;

  logic signed [WIDTH-1:0]  voices_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]    filt_q, off_q;
  logic [2:0]               mode_q;
  logic [3:0]               vol_q;

  logic signed [AccW-1:0]   v_ext, lp_t, bp_t, hp_t, mix_sum;
  logic signed [WIDTH+4:0]  clip_ext, vol_ext, prod;
  logic                     mix_clipped;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [AccW-1:0] x);
    if (x > MaxAcc) return MaxOut;
    if (x < MinAcc) return MinOut;
    return WIDTH'(x);
  endfunction

  assign v_ext = AccW'(voices_q[idx_q]) >>> HEADROOM;
  assign lp_t  = mode_q[0] ? AccW'(iLP) : '0;
  assign bp_t  = mode_q[1] ? AccW'(iBP) : '0;
  assign hp_t  = mode_q[2] ? AccW'(iHP) : '0;

`ifdef SID_MIX_DC_EN
  // Mixer input DC offset, scaled so it stays the same fraction of full scale at any WIDTH.
  localparam int DcShift = (WIDTH >= 16) ? int'(WIDTH) - 16 : 16 - int'(WIDTH);
  localparam int DcVal   = (WIDTH >= 16) ? (-3746 <<< DcShift) : (-3746 >>> DcShift);
  localparam logic signed [AccW-1:0] DcAcc = AccW'(DcVal);
  assign mix_sum = bacc_q + lp_t + bp_t + hp_t + DcAcc;
`else
  assign mix_sum = bacc_q + lp_t + bp_t + hp_t;
`endif

  assign mix_clipped = (mix_sum > MaxAcc) || (mix_sum < MinAcc);
  assign clip_ext    = (WIDTH + 5)'(clip_q);
  assign vol_ext     = {{(WIDTH + 1){1'b0}}, vol_q};
  assign prod        = clip_ext * vol_ext;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    facc_d  = facc_q;
    bacc_d  = bacc_q;
    clip_d  = clip_q;
    pf_d    = pf_q;
    out_d   = out_q;
    pre_d   = pre_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clkEn) begin
          latch   = 1'b1;
          facc_d  = '0;
          bacc_d  = '0;
          idx_d   = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (filt_q[idx_q])     facc_d = facc_q + v_ext;
        else if (!off_q[idx_q]) bacc_d = bacc_q + v_ext;
        if (idx_q == LastIdx) state_d = StMix;
        else                  idx_d   = idx_q + 1'b1;
      end
      StMix: begin
        clip_d = sat(mix_sum);
        pf_d   = sat(facc_q);
        if (mix_clipped && cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
        state_d = StVol;
      end
      StVol: begin
        out_d   = WIDTH'(prod >>> 4);
        pre_d   = pf_q;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (clkEn && state_q != StIdle) ovr_d = 1'b1;
    // Clear has priority over same-cycle clip or overrun events.
    if (iClr) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= StIdle;
      idx_q   <= '0;
      facc_q  <= '0;
      bacc_q  <= '0;
      clip_q  <= '0;
      pf_q    <= '0;
      out_q   <= '0;
      pre_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      facc_q  <= facc_d;
      bacc_q  <= bacc_d;
      clip_q  <= clip_d;
      pf_q    <= pf_d;
      out_q   <= out_d;
      pre_q   <= pre_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) voices_q[i] <= '0;
      filt_q <= '0;
      off_q  <= '0;
      mode_q <= '0;
      vol_q  <= '0;
    end else if (latch) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) voices_q[i] <= iVoices[i*WIDTH +: WIDTH];
      filt_q <= iFilt;
      off_q  <= iOff;
      mode_q <= iMode;
      vol_q  <= iVol;
    end
  end

  assign oOut       = out_q;
  assign oPreFilter = pre_q;
  assign oValid     = valid_q;
  assign oOverrun   = ovr_q;
  assign oClipCnt   = cnt_q;

endmodule

// File: doc/sid_mix_seq.md
# sid_mix_seq

Parametrised, time-multiplexed voice mixer and master-volume stage for multi-SID builds with NUM_VOICES voices. It replaces the fixed three-voice parallel adders in the SID top level. Once per 1 MHz `clkEn` tick it snapshots all voice amplitudes, accumulates one voice per clock into a filter-input sum and a bypass sum, and adds the selected filter outputs. It then clips, applies master volume, and emits a single-cycle `oValid` pulse.

## Interface
- NUM_VOICES, 3, voice count (1..24)
- WIDTH, 16, signed sample width of voices, filter taps and outputs (12..24)
- HEADROOM, 3, arithmetic right shift applied to each voice before summing
- clk  in  1  master clock
- iRstN  in  1  reset, asynchronous, active-low
- clkEn  in  1  sweep start strobe (1 MHz enable)
- iVoices  in  NUM_VOICES*WIDTH  signed voice amplitudes, voice i at [i*WIDTH +: WIDTH]
- iFilt  in  NUM_VOICES  route voice i to filter
- iOff  in  NUM_VOICES  disconnect voice i from bypass (ignored when iFilt[i]=1)
- iMode  in  3  add filter LP/BP/HP (bits 0/1/2) to output
- iVol  in  4  master volume 0..15
- iLP, iBP, iHP  in  WIDTH each  signed filter outputs
- iClr  in  1  synchronous clear of status
- oPreFilter  out  WIDTH  signed filter input sum
- oOut  out  WIDTH  signed mixed output
- oValid  out  1  one-cycle pulse when outputs are updated
- oOverrun  out  1  sticky: clkEn arrived while busy
- oClipCnt  out  8  saturating count of clipped sweeps

## Operation
- FSM states:
  - IDLE: on clkEn, latch iVoices, iFilt, iOff, iMode and iVol into shadow regs; clear both accumulators; idx=0; go to ACC.
  - ACC: each cycle take voice idx, v = shadow[idx] >>> HEADROOM.
    - If iFilt[idx]=1, add v to fAcc.
    - Else if iOff[idx]=0, add v to bAcc.
    - idx++. After idx=NUM_VOICES-1, go to MIX.
  - MIX: sample iLP/iBP/iHP this cycle.
    - m = bAcc + DC + the enabled filter taps.
    - Clip m to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. If clipped, oClipCnt++ (saturate at 255).
    - Saturate fAcc to WIDTH into pf.
    - Go to VOL.
  - VOL: oOut <= (clip × iVol) >>> 4 (signed, floor); oPreFilter <= pf; oValid <= 1; go to IDLE.
- Accumulator width: WIDTH + ceil(log2(NUM_VOICES+4)) + 1 bits, so no internal wrap is possible.
- Volume product width: WIDTH+5 signed. iVol is zero-extended.
- clkEn outside IDLE is ignored and sets oOverrun.
- iClr clears oOverrun and oClipCnt. If iClr and a clip or overrun occur in the same cycle, iClr wins.
- iVoices may change freely after the latch cycle; routing and volume changes take effect at the next sweep.

## Timing
- Edge E0 samples clkEn in IDLE. ACC occupies edges E1..E_N.
- MIX at E_{N+1}. Outputs and oValid are registered at E_{N+2}, so latency is NUM_VOICES+2 edges.
- oValid is high for exactly one cycle.
- Minimum clkEn spacing is NUM_VOICES+3 cycles. clkEn may be sampled in IDLE again on the cycle oValid is high.
- Reset values, all 0: oOut, oPreFilter, oValid, oOverrun, oClipCnt. FSM goes to IDLE and accumulators and shadows clear.
- Reset asserted mid-sweep aborts the sweep immediately. No oValid is produced, and the outputs read 0.
- oOut and oPreFilter hold their values between sweeps.

## Configuration
- SID_MIX_DC_EN defined: DC = -3746 scaled by 2^(WIDTH-16). The scaling is a left shift when WIDTH>16 and an arithmetic right shift when WIDTH<16. This models the mixer input DC offset of about -1/18 of one voice's range.
- SID_MIX_DC_EN undefined: DC = 0 and the adder term is removed.

## Test plan
Defaults: NUM_VOICES=3, WIDTH=16, HEADROOM=3, SID_MIX_DC_EN undefined unless stated.
- Reset: hold iRstN=0 with clkEn pulsing → all outputs 0, no oValid. Release → first oValid 5 edges after the first clkEn.
- Bypass: voices 8000/8000/8000, iFilt=0, iOff=0, iMode=0, iVol=15 → oOut=2812, oPreFilter=0.
- Disconnect: same stimulus with iOff=100 → oOut=1875. Then iFilt=100 with iOff=100 → oPreFilter=1000, oOut=1875.
- Clip: voices 8000 ×3, iMode=001, iLP=32767, iVol=15 → oOut=30719, oClipCnt=1.
  - iClr → oClipCnt=0.
- Overrun and abort:
  - clkEn at E0 and again at E2 → exactly one oValid at E5, oOverrun=1.
  - iRstN low at E3 of a sweep → no oValid, outputs 0.
- DC (macro defined): all inputs 0, iVol=15 → oOut=-3512. With iVol=0 → oOut=0.
